jtdd_vtiming_gen: RTL and testbench

// Parametrised video timing generator for the JTDD video subsystem; replaces fixed-geometry timing.

---
 rtl/jtdd_vtiming_gen.sv | 172 +++++++++++++++++
 tb/tb_jtdd_vtiming_gen.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_vtiming_gen.sv
// -----------------------------------------------------------------------------
// jtdd_vtiming_gen
// Parametrised video timing generator for the JTDD video subsystem.
// Produces pixel/line counters, blanking and sync flags, delayed active-low
// blanking, a programmable line interrupt strobe and a mid-screen level.
// Flip screen is applied to HPOS/VPOS and latched once per frame, on the edge
// where vcnt enters VB_START.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   pxl_cen    in   pixel clock enable; all state advances only when high
//   flip       in   flip-screen request
//   irq_vcmp   in   [VW] line number that triggers irq_stb
//   HPOS       out  [HW] horizontal position, flip applied
//   VPOS       out  [VW] vertical position, flip applied
//   HBL, VBL   out  horizontal / vertical blank, active high
//   HS, VS     out  horizontal / vertical sync, active high
//   LHBL_dly   out  ~HBL delayed BLK_DLY pixel ticks
//   LVBL_dly   out  ~VBL delayed BLK_DLY pixel ticks
//   irq_stb    out  one-clk strobe at the start of line irq_vcmp
//   ims        out  vcnt[IMS_BIT], never flipped
//   frame_cnt  out  [8] frame counter, only when JTDD_VTIMING_FCNT_EN is defined
//
// Optional feature macro: JTDD_VTIMING_FCNT_EN
// -----------------------------------------------------------------------------
module jtdd_vtiming_gen #(
   parameter int HW       = 9,
   parameter int VW       = 9,
   parameter int HTOTAL   = 384,
   parameter int VTOTAL   = 272,
   parameter int HB_START = 256,
   parameter int HB_END   = 0,
   parameter int HS_START = 296,
   parameter int HS_END   = 328,
   parameter int VB_START = 248,
   parameter int VB_END   = 8,
   parameter int VS_START = 252,
   parameter int VS_END   = 255,
   parameter int BLK_DLY  = 2,
   parameter int IMS_BIT  = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pxl_cen,
   input  logic          flip,
   input  logic [VW-1:0] irq_vcmp,
   output logic [HW-1:0] HPOS,
   output logic [VW-1:0] VPOS,
   output logic          HBL,
   output logic          VBL,
   output logic          HS,
   output logic          VS,
   output logic          LHBL_dly,
   output logic          LVBL_dly,
   output logic          irq_stb,
   output logic          ims
`ifdef JTDD_VTIMING_FCNT_EN
   ,
   output logic [7:0]    frame_cnt
`endif
);

   localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
   localparam logic [HW-1:0] HB_S   = HW'(HB_START);
   localparam logic [HW-1:0] HB_E   = HW'(HB_END);
   localparam logic [HW-1:0] HS_S   = HW'(HS_START);
   localparam logic [HW-1:0] HS_E   = HW'(HS_END);
   localparam logic [VW-1:0] VB_S   = VW'(VB_START);
   localparam logic [VW-1:0] VB_E   = VW'(VB_END);
   localparam logic [VW-1:0] VS_S   = VW'(VS_START);
   localparam logic [VW-1:0] VS_E   = VW'(VS_END);

   logic [HW-1:0] hcnt, hcnt_nxt;
   logic [VW-1:0] vcnt, vcnt_nxt;
   logic          line_start;
   logic          flip_l, flip_nxt;

   // Next-state values are shared by the counters and the registered
   // flags/positions so that everything lines up with the counter edge.
   always_comb begin
      line_start = (hcnt == H_LAST);
      hcnt_nxt   = line_start ? '0 : hcnt + 1'b1;
      vcnt_nxt   = vcnt;
      if (line_start) vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      flip_nxt   = (line_start && vcnt_nxt == VB_S) ? flip : flip_l;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hcnt    <= '0;
         vcnt    <= '0;
         flip_l  <= 1'b0;
         HPOS    <= '0;
         VPOS    <= '0;
         HBL     <= 1'b1;
         VBL     <= 1'b1;
         HS      <= 1'b0;
         VS      <= 1'b0;
         irq_stb <= 1'b0;
      end else begin
         irq_stb <= 1'b0;
         if (pxl_cen) begin
            hcnt   <= hcnt_nxt;
            vcnt   <= vcnt_nxt;
            flip_l <= flip_nxt;
            // Positions use the flip value taking effect on this same edge
            HPOS   <= hcnt_nxt ^ {HW{flip_nxt}};
            VPOS   <= vcnt_nxt ^ {VW{flip_nxt}};

            // Clear is tested first so START==END leaves the flag low
            if      (hcnt_nxt == HB_E) HBL <= 1'b0;
            else if (hcnt_nxt == HB_S) HBL <= 1'b1;
            if      (hcnt_nxt == HS_E) HS  <= 1'b0;
            else if (hcnt_nxt == HS_S) HS  <= 1'b1;

            if (line_start) begin
               if      (vcnt_nxt == VB_E) VBL <= 1'b0;
               else if (vcnt_nxt == VB_S) VBL <= 1'b1;
               if      (vcnt_nxt == VS_E) VS  <= 1'b0;
               else if (vcnt_nxt == VS_S) VS  <= 1'b1;
               // vcnt_nxt never exceeds VTOTAL-1, so out-of-range compares never fire
               irq_stb <= (vcnt_nxt == irq_vcmp);
            end
         end
      end
   end

   assign ims = vcnt[IMS_BIT];

   generate
      if (BLK_DLY == 0) begin : g_nodly
         assign LHBL_dly = ~HBL;
         assign LVBL_dly = ~VBL;
      end else if (BLK_DLY == 1) begin : g_dly1
         logic hdly, vdly;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               hdly <= 1'b0;
               vdly <= 1'b0;
            end else if (pxl_cen) begin
               hdly <= ~HBL;
               vdly <= ~VBL;
            end
         end
         assign LHBL_dly = hdly;
         assign LVBL_dly = vdly;
      end else begin : g_dlyn
         logic [BLK_DLY-1:0] hdly, vdly;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               hdly <= '0;
               vdly <= '0;
            end else if (pxl_cen) begin
               hdly <= {hdly[BLK_DLY-2:0], ~HBL};
               vdly <= {vdly[BLK_DLY-2:0], ~VBL};
            end
         end
         assign LHBL_dly = hdly[BLK_DLY-1];
         assign LVBL_dly = vdly[BLK_DLY-1];
      end
   endgenerate

`ifdef JTDD_VTIMING_FCNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                        frame_cnt <= '0;
      else if (pxl_cen && line_start && vcnt == V_LAST) frame_cnt <= frame_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_jtdd_vtiming_gen.sv
// -----------------------------------------------------------------------------
// tb_jtdd_vtiming_gen
// Two instances: one with the default geometry (directed table near reset and
// an asynchronous mid-line reset), one with a small geometry that is run
// through several frames under random pxl_cen/flip/irq_vcmp and compared with
// a position-from-tick-count reference model.
// -----------------------------------------------------------------------------
module tb_jtdd_vtiming_gen;

   typedef struct {
      int ht, vt, hbs, hbe, hss, hse, vbs, vbe, vss, vse, dly, ims, hw, vw;
   } geom_t;

   typedef struct {
      int tick;
      int hpos, vpos;
      bit hbl, hs, lhbl, irq;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // default-geometry instance
   logic       cen_d, flip_d;
   logic [8:0] vcmp_d;
   logic [8:0] d_hpos, d_vpos;
   logic       d_hbl, d_vbl, d_hs, d_vs, d_lhbl, d_lvbl, d_irq, d_ims;

   // small-geometry instance
   logic       cen_s, flip_s;
   logic [4:0] vcmp_s;
   logic [4:0] s_hpos, s_vpos;
   logic       s_hbl, s_vbl, s_hs, s_vs, s_lhbl, s_lvbl, s_irq, s_ims;

`ifdef JTDD_VTIMING_FCNT_EN
   logic [7:0] d_fcnt, s_fcnt;
`endif

   jtdd_vtiming_gen dut_d (
`ifdef JTDD_VTIMING_FCNT_EN
      .frame_cnt (d_fcnt),
`endif
      .clk      (clk),
      .rst      (rst),
      .pxl_cen  (cen_d),
      .flip     (flip_d),
      .irq_vcmp (vcmp_d),
      .HPOS     (d_hpos),
      .VPOS     (d_vpos),
      .HBL      (d_hbl),
      .VBL      (d_vbl),
      .HS       (d_hs),
      .VS       (d_vs),
      .LHBL_dly (d_lhbl),
      .LVBL_dly (d_lvbl),
      .irq_stb  (d_irq),
      .ims      (d_ims)
   );

   jtdd_vtiming_gen #(
      .HW(5), .VW(5), .HTOTAL(24), .VTOTAL(20),
      .HB_START(18), .HB_END(3), .HS_START(19), .HS_END(22),
      .VB_START(15), .VB_END(3), .VS_START(16), .VS_END(18),
      .BLK_DLY(3), .IMS_BIT(1)
   ) dut_s (
`ifdef JTDD_VTIMING_FCNT_EN
      .frame_cnt (s_fcnt),
`endif
      .clk      (clk),
      .rst      (rst),
      .pxl_cen  (cen_s),
      .flip     (flip_s),
      .irq_vcmp (vcmp_s),
      .HPOS     (s_hpos),
      .VPOS     (s_vpos),
      .HBL      (s_hbl),
      .VBL      (s_vbl),
      .HS       (s_hs),
      .VS       (s_vs),
      .LHBL_dly (s_lhbl),
      .LVBL_dly (s_lvbl),
      .irq_stb  (s_irq),
      .ims      (s_ims)
   );

   int    checks   = 0;
   int    failures = 0;
   geom_t gs;
   int    t_s;       // pixel ticks since reset, small instance
   bit    flip_m;    // model of the latched flip
   bit    irq_m;     // model of irq_stb

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit in_rng(int x, int s, int e);
      if (s == e) return 1'b0;
      if (s < e)  return (x >= s) && (x < e);
      return (x >= s) || (x < e);
   endfunction

   // First tick/line (counted from reset) at which the counter takes s or e
   function automatic int first_ev(int s, int e, int tot);
      int a, b;
      a = (s == 0) ? tot : s;
      b = (e == 0) ? tot : e;
      return (a < b) ? a : b;
   endfunction

   function automatic bit hflag(geom_t g, int t, int s, int e, bit rv);
      if (t < first_ev(s, e, g.ht)) return rv;
      return in_rng(t % g.ht, s, e);
   endfunction

   function automatic bit vflag(geom_t g, int t, int s, int e, bit rv);
      int line;
      line = t / g.ht;
      if (line < first_ev(s, e, g.vt)) return rv;
      return in_rng(line % g.vt, s, e);
   endfunction

   function automatic bit lhbl_exp(geom_t g, int t);
      if (t < g.dly) return 1'b0;
      return ~hflag(g, t - g.dly, g.hbs, g.hbe, 1'b1);
   endfunction

   function automatic bit lvbl_exp(geom_t g, int t);
      if (t < g.dly) return 1'b0;
      return ~vflag(g, t - g.dly, g.vbs, g.vbe, 1'b1);
   endfunction

   task automatic model_edge(input bit cen, input bit fl, input int vc);
      int h, v;
      if (cen) begin
         t_s++;
         h = t_s % gs.ht;
         v = (t_s / gs.ht) % gs.vt;
         irq_m = (h == 0) && (v == vc);
         if (h == 0 && v == gs.vbs) flip_m = fl;
      end else begin
         irq_m = 1'b0;
      end
   endtask

   task automatic check_small();
      int h, v, hm, vm;
      h  = t_s % gs.ht;
      v  = (t_s / gs.ht) % gs.vt;
      hm = flip_m ? ((1 << gs.hw) - 1) : 0;
      vm = flip_m ? ((1 << gs.vw) - 1) : 0;
      chk("s_hpos", s_hpos, h ^ hm);
      chk("s_vpos", s_vpos, v ^ vm);
      chk("s_hbl",  s_hbl,  hflag(gs, t_s, gs.hbs, gs.hbe, 1'b1));
      chk("s_hs",   s_hs,   hflag(gs, t_s, gs.hss, gs.hse, 1'b0));
      chk("s_vbl",  s_vbl,  vflag(gs, t_s, gs.vbs, gs.vbe, 1'b1));
      chk("s_vs",   s_vs,   vflag(gs, t_s, gs.vss, gs.vse, 1'b0));
      chk("s_lhbl", s_lhbl, lhbl_exp(gs, t_s));
      chk("s_lvbl", s_lvbl, lvbl_exp(gs, t_s));
      chk("s_irq",  s_irq,  irq_m);
      chk("s_ims",  s_ims,  (v >> gs.ims) & 1);
`ifdef JTDD_VTIMING_FCNT_EN
      chk("s_fcnt", s_fcnt, (t_s / (gs.ht * gs.vt)) % 256);
`endif
   endtask

   task automatic reset_small();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst    = 1'b1;
      t_s    = 0;
      flip_m = 1'b0;
      irq_m  = 1'b0;
   endtask

   // n pixel ticks on the small instance with pxl_cen held high
   task automatic run_small(input int n, output int ones, output int rises);
      bit prev;
      ones = 0; rises = 0; prev = 1'b0;
      for (int i = 0; i < n; i++) begin
         cen_s = 1'b1;
         model_edge(1'b1, flip_s, vcmp_s);
         @(negedge clk);
         check_small();
         if (s_irq === 1'b1) ones++;
         if (s_irq === 1'b1 && !prev) rises++;
         prev = (s_irq === 1'b1);
      end
   endtask

   vec_t tbl[16];
   int   td;
   int   ones, rises;

   initial begin
      gs = '{ht:24, vt:20, hbs:18, hbe:3, hss:19, hse:22, vbs:15, vbe:3,
             vss:16, vse:18, dly:3, ims:1, hw:5, vw:5};

      //          tick hpos vpos hbl hs lhbl irq
      tbl[0]  = '{  0,   0,  0, 1, 0, 0, 0};
      tbl[1]  = '{  1,   1,  0, 1, 0, 0, 0};
      tbl[2]  = '{  2,   2,  0, 1, 0, 0, 0};
      tbl[3]  = '{296, 296,  0, 1, 1, 0, 0};
      tbl[4]  = '{383, 383,  0, 1, 0, 0, 0};
      tbl[5]  = '{384,   0,  1, 0, 0, 0, 0};
      tbl[6]  = '{386,   2,  1, 0, 0, 1, 0};
      tbl[7]  = '{639, 255,  1, 0, 0, 1, 0};
      tbl[8]  = '{640, 256,  1, 1, 0, 1, 0};
      tbl[9]  = '{642, 258,  1, 1, 0, 0, 0};
      tbl[10] = '{679, 295,  1, 1, 0, 0, 0};
      tbl[11] = '{680, 296,  1, 1, 1, 0, 0};
      tbl[12] = '{711, 327,  1, 1, 1, 0, 0};
      tbl[13] = '{712, 328,  1, 1, 0, 0, 0};
      tbl[14] = '{768,   0,  2, 0, 0, 0, 1};
      tbl[15] = '{769,   1,  2, 0, 0, 0, 0};

      rst    = 1'b0;
      cen_d  = 1'b0; flip_d = 1'b0; vcmp_d = 9'd2;
      cen_s  = 1'b0; flip_s = 1'b0; vcmp_s = 5'd0;
      repeat (3) @(negedge clk);

      // reset state, default instance
      chk("rst_vbl",  d_vbl,  1);
      chk("rst_vs",   d_vs,   0);
      chk("rst_lvbl", d_lvbl, 0);
      chk("rst_ims",  d_ims,  0);
`ifdef JTDD_VTIMING_FCNT_EN
      chk("rst_fcnt", d_fcnt, 0);
`endif

      // ---------------- table-driven, default geometry ----------------
      rst   = 1'b1;
      cen_d = 1'b1;
      td    = 0;
      for (int i = 0; i < 16; i++) begin
         while (td < tbl[i].tick) begin
            @(negedge clk);
            td++;
         end
         chk("d_hpos", d_hpos, tbl[i].hpos);
         chk("d_vpos", d_vpos, tbl[i].vpos);
         chk("d_hbl",  d_hbl,  tbl[i].hbl);
         chk("d_hs",   d_hs,   tbl[i].hs);
         chk("d_lhbl", d_lhbl, tbl[i].lhbl);
         chk("d_irq",  d_irq,  tbl[i].irq);
         chk("d_vbl",  d_vbl,  1);
      end

      // asynchronous reset in the middle of line 2, hcnt=200
      while (td < 968) begin
         @(negedge clk);
         td++;
      end
      chk("pre_rst_hpos", d_hpos, 200);
      #2 rst = 1'b0;
      #1;
      chk("arst_hpos", d_hpos, 0);
      chk("arst_vpos", d_vpos, 0);
      chk("arst_hbl",  d_hbl,  1);
      chk("arst_vbl",  d_vbl,  1);
      chk("arst_hs",   d_hs,   0);
      chk("arst_lhbl", d_lhbl, 0);
      chk("arst_lvbl", d_lvbl, 0);
      chk("arst_irq",  d_irq,  0);
      repeat (3) @(negedge clk);
      chk("arst_hold_hpos", d_hpos, 0);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("restart_hpos", d_hpos, 5);
      chk("restart_vpos", d_vpos, 0);
      chk("restart_hbl",  d_hbl,  1);

      // no pxl_cen: nothing moves
      cen_d = 1'b0;
      repeat (20) @(negedge clk);
      chk("hold_hpos", d_hpos, 5);
      chk("hold_vpos", d_vpos, 0);

      // ---------------- random stimulus, small geometry ----------------
      reset_small();
      for (int i = 0; i < 6000; i++) begin
         check_small();
         cen_s = ($urandom % 4) != 0;
         if ($urandom % 50 == 0)  flip_s = ~flip_s;
         if ($urandom % 200 == 0) vcmp_s = 5'($urandom_range(0, 25));
         model_edge(cen_s, flip_s, vcmp_s);
         @(negedge clk);
      end

      // one irq per frame, each one clk wide
      flip_s = 1'b0;
      vcmp_s = 5'd7;
      reset_small();
      run_small(3 * 480, ones, rises);
      chk("irq_ones",  ones,  3);
      chk("irq_rises", rises, 3);

      // irq_vcmp beyond the frame never fires
      vcmp_s = 5'd25;
      run_small(480, ones, rises);
      chk("irq_oob", ones, 0);

      // flip requested mid-frame, latched only when vcnt enters 15
      vcmp_s = 5'd0;
      reset_small();
      run_small(120, ones, rises);
      flip_s = 1'b1;
      run_small(341 - 120, ones, rises);
      chk("flip_wait_hpos", s_hpos, 5);
      chk("flip_wait_vpos", s_vpos, 14);
      run_small(24, ones, rises);
      chk("flip_on_hpos", s_hpos, 26);
      chk("flip_on_vpos", s_vpos, 16);
      flip_s = 1'b0;
      run_small(408 - 365, ones, rises);
      chk("flip_kept_hpos", s_hpos, 31);
      chk("flip_kept_vpos", s_vpos, 14);
      chk("flip_ims",       s_ims,  0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
